// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU datapath and its issue/writeback controller.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREGS = 4;
    localparam int NFLAGS        = 6;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_SUB = 2'b01,
        OP_ADD = 2'b10,
        OP_MUL = 2'b11
    } alu_op_e;

    // Bit positions inside the {z, n, vn, vp, br, c} flag vector
    localparam int FLG_C  = 0;
    localparam int FLG_BR = 1;
    localparam int FLG_VP = 2;
    localparam int FLG_VN = 3;
    localparam int FLG_N  = 4;
    localparam int FLG_Z  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WB    = 2'b10
    } issue_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write port.
module regfile_2r1w #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Register/issue stage of the 8-bit datapath: accepts one instruction, drives the
// combinational ALU for one cycle, captures result and flags, then writes back.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREGS = DEFAULT_NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     instr_ldi,
    input  logic [1:0]               instr_op,
    input  logic [$clog2(NREGS)-1:0] instr_rd,
    input  logic [$clog2(NREGS)-1:0] instr_rs1,
    input  logic [$clog2(NREGS)-1:0] instr_rs2,
    input  logic [WIDTH-1:0]         instr_imm,
    output logic [1:0]               alu_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_r,
    input  logic [NFLAGS-1:0]        alu_flags,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [WIDTH-1:0]         wb_data,
    output logic [NFLAGS-1:0]        flags,
    output logic                     busy,
    output issue_state_e             dbg_state
);

    localparam int AW = $clog2(NREGS);

    issue_state_e      state_q, state_d;
    logic              ldi_q;
    alu_op_e           op_q;
    logic [AW-1:0]     rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0]  res_q;
    logic [NFLAGS-1:0] flags_q;
    logic [WIDTH-1:0]  rdata_a, rdata_b;
    logic              accept;
    alu_op_e           alu_op_d;
    logic [WIDTH-1:0]  alu_a_d, alu_b_d;

    // Writeback of an ALU op overlaps the next accept, so ALU ops sustain one per
    // two cycles; an LDI writeback returns through IDLE, also two cycles per LDI.
    assign instr_ready = (state_q == IDLE) || ((state_q == WB) && !ldi_q);
    assign busy        = ~instr_ready;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d  = state_q;
        alu_op_d = OP_AND;
        alu_a_d  = '0;
        alu_b_d  = '0;
        unique case (state_q)
            IDLE, WB: begin
                if (accept) begin
                    state_d = instr_ldi ? WB : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d  = WB;
                alu_op_d = op_q;
                alu_a_d  = rdata_a;
                alu_b_d  = rdata_b;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ldi_q   <= 1'b0;
            op_q    <= OP_AND;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ldi_q <= instr_ldi;
                op_q  <= alu_op_e'(instr_op);
                rd_q  <= instr_rd;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
                if (instr_ldi) begin
                    res_q <= instr_imm;
                end
            end
            if (state_q == ISSUE) begin
                res_q   <= alu_r;
                flags_q <= alu_flags;
            end
        end
    end

    regfile_2r1w #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (state_q == WB),
        .waddr   (rd_q),
        .wdata   (res_q),
        .raddr_a (rs1_q),
        .rdata_a (rdata_a),
        .raddr_b (rs2_q),
        .rdata_b (rdata_b)
    );

    assign alu_op    = alu_op_d;
    assign alu_a     = alu_a_d;
    assign alu_b     = alu_b_d;
    assign wb_valid  = (state_q == WB);
    assign wb_rd     = rd_q;
    assign wb_data   = res_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_r/alu_flags, and an
// arithmetic reference model with its own register array predicts every writeback.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid, instr_ready, instr_ldi;
    logic [1:0]   instr_op, instr_rd, instr_rs1, instr_rs2;
    logic [7:0]   instr_imm;
    logic [1:0]   alu_op;
    logic [7:0]   alu_a, alu_b, alu_r;
    logic [5:0]   alu_flags;
    logic         wb_valid;
    logic [1:0]   wb_rd;
    logic [7:0]   wb_data;
    logic [5:0]   flags;
    logic         busy;
    issue_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_rf [4];
    logic [5:0] m_flags;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_ldi(instr_ldi), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags(flags), .busy(busy), .dbg_state(dbg_state)
    );

    // Stand-in for the team combinational ALU
    logic [8:0]  sum9, dif9;
    logic [15:0] prod;
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b};
        dif9      = {1'b0, alu_a} - {1'b0, alu_b};
        prod      = alu_a * alu_b;
        alu_r     = '0;
        alu_flags = '0;
        case (alu_op)
            2'b00: alu_r = alu_a & alu_b;
            2'b01: begin
                alu_r             = dif9[7:0];
                alu_flags[FLG_BR] = dif9[8];
                alu_flags[FLG_VP] = ~alu_a[7] & alu_b[7] & dif9[7];
                alu_flags[FLG_VN] = alu_a[7] & ~alu_b[7] & ~dif9[7];
            end
            2'b10: begin
                alu_r             = sum9[7:0];
                alu_flags[FLG_C]  = sum9[8];
                alu_flags[FLG_VP] = ~alu_a[7] & ~alu_b[7] & sum9[7];
                alu_flags[FLG_VN] = alu_a[7] & alu_b[7] & ~sum9[7];
            end
            default: alu_r = prod[7:0];
        endcase
        alu_flags[FLG_Z] = (alu_r == 8'h00);
        alu_flags[FLG_N] = alu_r[7];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers
    task automatic model_alu(input int op, input int a, input int b,
                             output logic [7:0] r, output logic [5:0] f);
        int full, sa, sb, ss;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        f  = '0;
        case (op)
            0: full = a & b;
            1: begin
                full      = a - b;
                ss        = sa - sb;
                f[FLG_BR] = (a < b);
                f[FLG_VP] = (ss > 127);
                f[FLG_VN] = (ss < -128);
            end
            2: begin
                full      = a + b;
                ss        = sa + sb;
                f[FLG_C]  = (full > 255);
                f[FLG_VP] = (ss > 127);
                f[FLG_VN] = (ss < -128);
            end
            default: full = a * b;
        endcase
        full     = ((full % 256) + 256) % 256;
        r        = 8'(full);
        f[FLG_Z] = (full == 0);
        f[FLG_N] = (full >= 128);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = '0;
    endtask

    task automatic scramble();
        instr_valid = 1'($urandom_range(0, 1));
        instr_ldi   = 1'($urandom_range(0, 1));
        instr_op    = 2'($urandom_range(0, 3));
        instr_rd    = 2'($urandom_range(0, 3));
        instr_rs1   = 2'($urandom_range(0, 3));
        instr_rs2   = 2'($urandom_range(0, 3));
        instr_imm   = 8'($urandom_range(0, 255));
    endtask

    // Called at a falling edge while the controller is ready; returns at the falling
    // edge where it is ready for the next instruction.
    task automatic send(input logic ldi, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
        logic [7:0] er;
        logic [5:0] ef;
        check("ready_before", instr_ready, 1);
        instr_valid = 1'b1;
        instr_ldi   = ldi;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_imm   = imm;
        @(negedge clk);
        if (!ldi) begin
            model_alu(int'(op), int'(m_rf[rs1]), int'(m_rf[rs2]), er, ef);
            check("issue_state", dbg_state, ISSUE);
            check("issue_busy", busy, 1);
            check("issue_wb_valid", wb_valid, 0);
            check("issue_alu_op", alu_op, op);
            check("issue_alu_a", alu_a, m_rf[rs1]);
            check("issue_alu_b", alu_b, m_rf[rs2]);
            scramble();
            @(negedge clk);
            check("alu_wb_valid", wb_valid, 1);
            check("alu_wb_rd", wb_rd, rd);
            check("alu_wb_data", wb_data, er);
            check("alu_flags", flags, ef);
            check("alu_wb_alu_zero", {alu_op, alu_a, alu_b}, 0);
            check("alu_wb_ready", instr_ready, 1);
            m_flags = ef;
            m_rf[rd] = er;
        end else begin
            check("ldi_wb_valid", wb_valid, 1);
            check("ldi_wb_rd", wb_rd, rd);
            check("ldi_wb_data", wb_data, imm);
            check("ldi_flags", flags, m_flags);
            check("ldi_alu_zero", {alu_op, alu_a, alu_b}, 0);
            check("ldi_wb_ready", instr_ready, 0);
            scramble();
            @(negedge clk);
            m_rf[rd] = imm;
            check("ldi_after_wb_valid", wb_valid, 0);
            check("ldi_after_state", dbg_state, IDLE);
        end
    endtask

    task automatic gap();
        instr_valid = 1'b0;
        @(negedge clk);
        check("gap_wb_valid", wb_valid, 0);
        check("gap_ready", instr_ready, 1);
        check("gap_alu_zero", {alu_op, alu_a, alu_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] imm;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_ldi   = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_imm   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", flags, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("rst_state", dbg_state, IDLE);

        send(1'b1, 2'b00, 2'd1, 2'd0, 2'd0, 8'h05);
        send(1'b1, 2'b00, 2'd2, 2'd0, 2'd0, 8'hFD);
        check("ldi_flags_zero", flags, 0);
        send(1'b0, 2'b10, 2'd3, 2'd1, 2'd2, 8'h00);
        check("add_data", wb_data, 8'h02);
        check("add_c", flags[FLG_C], 1);
        check("add_z", flags[FLG_Z], 0);
        send(1'b0, 2'b01, 2'd0, 2'd1, 2'd1, 8'h00);
        check("sub_data", wb_data, 8'h00);
        check("sub_z", flags[FLG_Z], 1);
        check("sub_n", flags[FLG_N], 0);
        send(1'b0, 2'b11, 2'd3, 2'd1, 2'd2, 8'h00);
        check("mul_data", wb_data, 8'hF1);
        check("mul_n", flags[FLG_N], 1);

        // Four back-to-back ALU ops with instr_valid held high
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'h00);
        end
        gap();

        // Reset while an ALU op is in ISSUE
        instr_valid = 1'b1;
        instr_ldi   = 1'b0;
        instr_op    = 2'b10;
        instr_rd    = 2'd1;
        instr_rs1   = 2'd1;
        instr_rs2   = 2'd2;
        @(negedge clk);
        check("abort_in_issue", dbg_state, ISSUE);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("abort_state", dbg_state, IDLE);
        check("abort_alu_zero", {alu_op, alu_a, alu_b}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_wb_valid", wb_valid, 0);
            check("abort_flags", flags, 0);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        send(1'b0, 2'b10, 2'd2, 2'd1, 2'd1, 8'h00);
        check("abort_r1_zero", wb_data, 8'h00);

        // Randomized mix of LDI/ALU ops with boundary immediates and idle gaps
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: imm = 8'h00;
                1: imm = 8'hFF;
                2: imm = 8'h80;
                3: imm = 8'h7F;
                default: imm = 8'($urandom_range(0, 255));
            endcase
            send(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), imm);
            if ($urandom_range(0, 3) == 0) gap();
        end
        gap();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
